pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, number of dmem wait cycles before dmem_err sets (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in IF/ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  the instruction in IF/ID reads that source.
REQ-006 ex_rd  in  5  destination of the instruction in ID/EX.
REQ-007 ex_lw  in  1  the instruction in ID/EX is a load.
REQ-008 mem_lw, mem_escmem  in  1 each  EX/MEM holds a load or a store.
REQ-009 mem_jump, mem_jalr, mem_branch_taken  in  1 each  control-flow redirect resolved in the MEM stage.
REQ-010 dmem_ready  in  1  data memory completes the current access this cycle.
REQ-011 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage register load enables.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_bubble  out  1 each  insert a bubble into that stage register.
REQ-013 pc_redirect  out  1  PC takes the redirect target this cycle.
REQ-014 dmem_req  out  1  data memory access request.
REQ-015 dmem_err  out  1  sticky timeout flag.
REQ-016 stall_cycles  out  32  count of cycles with pc_en = 0.

Function
REQ-017 FSM states: RUN, MEM_WAIT, REDIRECT. State encoding is internal.
REQ-018 dmem_req = (mem_lw | mem_escmem) in RUN and in MEM_WAIT.
REQ-019 Mem stall has the highest priority.
- Condition: dmem_req = 1 and dmem_ready = 0.
- pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1.
- No flushes and no redirect during the stall.
- Next state: MEM_WAIT.
REQ-020 MEM_WAIT: holds the same outputs as REQ-019 until dmem_ready = 1.
- wait_cnt (8 bits) increments each waiting cycle and saturates at TIMEOUT.
- dmem_err sets when wait_cnt reaches TIMEOUT and stays set until reset.
- The stall continues after timeout.
REQ-021 On dmem_ready = 1 in MEM_WAIT: all enables = 1, wait_cnt cleared.
- Redirect inputs are re-evaluated in the same cycle per REQ-022.
REQ-022 Redirect (second priority) applies when not mem-stalled and any of mem_jump, mem_jalr, mem_branch_taken = 1.
- pc_redirect = 1.
- ifid_flush = idex_flush = exmem_flush = 1.
- All enables = 1.
- Next state: REDIRECT.
REQ-023 REDIRECT lasts exactly one cycle.
- ifid_flush = 1 to discard the fetch issued before the redirect.
- Load-use detection is suppressed.
- Next state: RUN, unless REQ-019 applies, which takes priority.
REQ-024 Load-use (lowest priority) applies in RUN when:
- ex_lw = 1, ex_rd != 0, and (id_use_rs1 & id_rs1 == ex_rd) or (id_use_rs2 & id_rs2 == ex_rd).
- Response: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = 1.
- State stays RUN.
REQ-025 With no condition active: all enables = 1, all flushes and bubbles = 0, pc_redirect = 0.
REQ-026 stall_cycles increments by 1 in every cycle with pc_en = 0 and wraps modulo 2^32.
REQ-027 Flush and enable for the same stage are both 1 only on a flush; the flush wins (the stage loads a bubble).

Reset
REQ-028 While reset = 0:
- state = RUN, wait_cnt = 0, dmem_err = 0, stall_cycles = 0.
- All enables = 0, all flushes and memwb_bubble = 1, pc_redirect = 0, dmem_req = 0.
REQ-029 Reset asserted mid-MEM_WAIT or mid-REDIRECT aborts the operation immediately, with no pending effect after release.
REQ-030 The first cycle after release behaves as RUN.

Structure
REQ-031 The shared pipeline package holds:
- the FSM state enum,
- TIMEOUT default,
- register-index width (5),
- the x0 constant.
REQ-032 Load-use comparison is one combinational sub-module, hazard_detect; all sequencing stays in pipe_hazard_ctrl.

Verification
REQ-033 Load-use: ex_lw=1, ex_rd=5, id_rs1=5, id_use_rs1=1.
- Exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1.
- stall_cycles +1.
REQ-034 x0 load: ex_rd=0, id_rs1=0, ex_lw=1.
- No stall; all enables 1.
REQ-035 Store wait: mem_escmem=1, dmem_ready=0 for 3 cycles, then 1.
- 3 frozen cycles with memwb_bubble=1, then normal flow.
- stall_cycles = 3.
REQ-036 Redirect: mem_branch_taken=1 in RUN.
- Cycle 0: pc_redirect=1 and three flushes.
- Cycle 1: ifid_flush only.
- A load-use condition in cycle 1 is ignored.
REQ-037 Priority and timeout: mem_jump=1 with dmem_req=1, dmem_ready=0.
- No redirect until ready.
- With TIMEOUT=4 and 6 wait cycles: dmem_err=1 from the 4th wait cycle, still set after ready.
- Asserting reset clears dmem_err to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// register-index width, the x0 index and the default dmem timeout.
package pipe_hazard_ctrl_pkg;

  localparam int TIMEOUT_DEF = 255;
  localparam int REG_W       = 5;
  localparam int WAIT_W      = 8;

  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard-controller signal bundle. The controller uses the slave
// modport; the pipeline datapath (or a testbench) uses the master modport.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  // Hazard inputs from the pipeline stage registers.
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_lw;
  logic             mem_lw;
  logic             mem_escmem;
  logic             mem_jump;
  logic             mem_jalr;
  logic             mem_branch_taken;

  // Data-memory handshake: an access is offered while dmem_req = 1 and
  // completes in the cycle where dmem_ready = 1; dmem_req stays high (and the
  // pipeline stays frozen) for every cycle the access is outstanding.
  logic             dmem_req;
  logic             dmem_ready;
  logic             dmem_err;

  // Stage controls back to the pipeline.
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             pc_redirect;
  logic [31:0]      stall_cycles;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_lw,
           mem_lw, mem_escmem, mem_jump, mem_jalr, mem_branch_taken,
           dmem_ready,
    output dmem_req, dmem_err,
           pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           pc_redirect, stall_cycles
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_lw,
           mem_lw, mem_escmem, mem_jump, mem_jalr, mem_branch_taken,
           dmem_ready,
    input  dmem_req, dmem_err,
           pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble,
           pc_redirect, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination is read by the
// instruction in IF/ID. Writes to x0 never create a dependency.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             ex_lw,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_lw && (ex_rd != X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory stall > MEM-stage redirect > load-use,
// with a sticky dmem timeout flag and a free-running stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus,
  output state_t             dbg_state
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              err_q;
  logic [31:0]       stall_cnt;

  logic load_use;
  logic mem_access;
  logic mem_stall;
  logic redirect_in;

  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic pc_redirect, dmem_req;

  hazard_detect u_hazard_detect (
    .ex_lw      (bus.ex_lw),
    .ex_rd      (bus.ex_rd),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .load_use   (load_use)
  );

  assign mem_access  = bus.mem_lw | bus.mem_escmem;
  assign redirect_in = bus.mem_jump | bus.mem_jalr | bus.mem_branch_taken;
  assign mem_stall   = reset && mem_access && !bus.dmem_ready;
  assign wait_cnt_n  = (wait_cnt == TIMEOUT_CNT) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (mem_stall) begin
        wait_cnt <= wait_cnt_n;
        if (wait_cnt_n == TIMEOUT_CNT) err_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (!pc_en) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    state_n      = state;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    pc_redirect  = 1'b0;
    dmem_req     = mem_access;

    if (mem_stall) begin
      // Freeze everything up to EX/MEM; MEM/WB receives bubbles meanwhile.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_n      = MEM_WAIT;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          state_n = RUN;
          if (redirect_in) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_n     = REDIRECT;
          end else if (state == RUN && load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        REDIRECT: begin
          // Drop the wrong-path fetch issued alongside the redirect.
          ifid_flush = 1'b1;
          state_n    = RUN;
        end
        default: state_n = RUN;
      endcase
    end

    if (!reset) begin
      state_n      = RUN;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
      pc_redirect  = 1'b0;
      dmem_req     = 1'b0;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.pc_redirect  = pc_redirect;
  assign bus.dmem_req     = dmem_req;
  assign bus.dmem_err     = err_q;
  assign bus.stall_cycles = stall_cnt;
  assign dbg_state        = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: control vectors go through an expected
// queue; stall counter, error flag and FSM state are checked after each edge.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // Control vector: {pc,ifid,idex,exmem en, ifid,idex,exmem flush, bubble, redirect, req}
  localparam logic [9:0] V_RST     = 10'b0000_1111_00;
  localparam logic [9:0] V_NORM    = 10'b1111_0000_00;
  localparam logic [9:0] V_NORMREQ = 10'b1111_0000_01;
  localparam logic [9:0] V_LU      = 10'b0011_0100_00;
  localparam logic [9:0] V_STALL   = 10'b0000_0001_01;
  localparam logic [9:0] V_REDIR   = 10'b1111_1110_10;
  localparam logic [9:0] V_REDIRRQ = 10'b1111_1110_11;
  localparam logic [9:0] V_POSTRD  = 10'b1111_1000_00;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [9:0]  exp_q[$];
  logic [9:0]  obs;
  logic [31:0] sc_exp;
  int          checks;
  int          errors;

  assign obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                bus.memwb_bubble, bus.pc_redirect, bus.dmem_req};

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.id_rs1           = '0;
    bus.id_rs2           = '0;
    bus.id_use_rs1       = 1'b0;
    bus.id_use_rs2       = 1'b0;
    bus.ex_rd            = '0;
    bus.ex_lw            = 1'b0;
    bus.mem_lw           = 1'b0;
    bus.mem_escmem       = 1'b0;
    bus.mem_jump         = 1'b0;
    bus.mem_jalr         = 1'b0;
    bus.mem_branch_taken = 1'b0;
    bus.dmem_ready       = 1'b1;
  endtask

  task automatic load_use_inputs(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic u1, input logic [4:0] rs2, input logic u2);
    bus.ex_lw      = 1'b1;
    bus.ex_rd      = rd;
    bus.id_rs1     = rs1;
    bus.id_use_rs1 = u1;
    bus.id_rs2     = rs2;
    bus.id_use_rs2 = u2;
  endtask

  // One clock: queue the expected control vector, compare it mid-cycle,
  // then compare the stall counter just after the edge.
  task automatic step(input string tag, input logic [9:0] expv);
    logic [9:0] e;
    exp_q.push_back(expv);
    #2;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s ctl got=%b exp=%b", tag, obs, e);
    end
    if (!reset)     sc_exp = '0;
    else if (!e[9]) sc_exp = sc_exp + 32'd1;
    @(posedge clk);
    #1;
    checks++;
    assert (bus.stall_cycles === sc_exp) else begin
      errors++;
      $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, bus.stall_cycles, sc_exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t e);
    checks++;
    assert (dbg_state === e) else begin
      errors++;
      $error("FAIL %s state got=%s exp=%s", tag, dbg_state.name(), e.name());
    end
  endtask

  task automatic chk_err(input string tag, input logic e);
    checks++;
    assert (bus.dmem_err === e) else begin
      errors++;
      $error("FAIL %s dmem_err got=%b exp=%b", tag, bus.dmem_err, e);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    sc_exp = '0;
    reset  = 1'b0;
    idle();

    // Reset state
    step("rst0", V_RST);
    step("rst1", V_RST);
    chk_state("rst", RUN);
    chk_err("rst", 1'b0);
    reset = 1'b1;
    step("idle", V_NORM);
    chk_state("idle", RUN);

    // Load-use on rs1, then on rs2, then non-hazards
    load_use_inputs(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step("lu_rs1", V_LU);
    chk_state("lu_rs1", RUN);
    idle();
    step("lu_after", V_NORM);
    load_use_inputs(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    step("lu_rs2", V_LU);
    load_use_inputs(5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
    step("lu_nouse", V_NORM);
    load_use_inputs(5'd7, 5'd7, 1'b1, 5'd1, 1'b1);
    bus.ex_lw = 1'b0;
    step("lu_notload", V_NORM);
    load_use_inputs(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    step("lu_x0", V_NORM);
    idle();

    // Store wait: 3 frozen cycles then completion
    bus.mem_escmem = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("st_wait%0d", i), V_STALL);
      chk_state("st_wait", MEM_WAIT);
    end
    chk_err("st_wait", 1'b0);
    bus.dmem_ready = 1'b1;
    step("st_done", V_NORMREQ);
    chk_state("st_done", RUN);
    idle();
    step("st_after", V_NORM);

    // Redirect, with a load-use in the following cycle suppressed
    bus.mem_branch_taken = 1'b1;
    step("br_c0", V_REDIR);
    chk_state("br_c0", REDIRECT);
    idle();
    load_use_inputs(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step("br_c1", V_POSTRD);
    chk_state("br_c1", RUN);
    step("br_lu", V_LU);
    idle();
    step("br_after", V_NORM);

    // Jump behind a stalled load, timeout after the 4th wait cycle
    bus.mem_jump   = 1'b1;
    bus.mem_lw     = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step($sformatf("to_wait%0d", k), V_STALL);
      chk_err($sformatf("to_wait%0d", k), (k >= 4) ? 1'b1 : 1'b0);
    end
    bus.dmem_ready = 1'b1;
    step("to_ready", V_REDIRRQ);
    chk_state("to_ready", REDIRECT);
    chk_err("to_ready", 1'b1);
    idle();
    step("to_c1", V_POSTRD);
    chk_err("to_c1", 1'b1);
    step("to_after", V_NORM);
    reset = 1'b0;
    step("to_rst", V_RST);
    chk_err("to_rst", 1'b0);
    reset = 1'b1;

    // Reset in the middle of a memory wait leaves nothing pending
    bus.mem_escmem = 1'b1;
    bus.dmem_ready = 1'b0;
    step("ab_wait0", V_STALL);
    step("ab_wait1", V_STALL);
    chk_state("ab_wait", MEM_WAIT);
    reset = 1'b0;
    idle();
    step("ab_rst", V_RST);
    chk_state("ab_rst", RUN);
    reset = 1'b1;
    step("ab_run", V_NORM);
    chk_state("ab_run", RUN);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
